counter_4b_checker: RTL and testbench

COUNTER_4B_CHECKER -- requirements
Module: counter_4b_checker

---
 rtl/counter_4b_checker.sv | 175 +++++++++++++++++
 tb/tb_counter_4b_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_4b_checker.sv
// counter_4b_checker
//
// Purpose:
//   On-line checker for a 4-bit multi-mode counter. The monitored counter's
//   stimulus (mon_reset, mon_enable, mon_mode, mon_D) and outputs (mon_Q,
//   mon_rco, mon_load) are observed every clock. A reference model predicts
//   what the counter should show after each edge, and that prediction is
//   compared against the counter outputs one edge later.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous active-low reset of the checker
//   check_en     - 1 = monitor, 0 = return to IDLE
//   mon_reset    - counter's active-high reset as driven to the counter
//   mon_enable   - counter's enable
//   mon_mode     - counter's mode (00 +3, 01 -1, 10 +1, 11 load)
//   mon_D        - counter's parallel-load data
//   mon_Q        - counter output Q
//   mon_rco      - counter output rco
//   mon_load     - counter output load
//   err_pulse    - one-cycle pulse when a compare finds any difference
//   err_vec      - {Q, rco, load} difference flags, valid with err_pulse
//   err_count    - saturating count of failed compares
//   match_count  - wrapping count of clean compares
//   state        - IDLE=00, SYNC=01, CHECK=10, HALT=11

module counter_4b_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic       check_en,
  input  logic       mon_reset,
  input  logic       mon_enable,
  input  logic [1:0] mon_mode,
  input  logic [3:0] mon_D,
  input  logic [3:0] mon_Q,
  input  logic       mon_rco,
  input  logic       mon_load,
  output logic       err_pulse,
  output logic [2:0] err_vec,
  output logic [7:0] err_count,
  output logic [7:0] match_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    CHECK = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t     cur_state;

  // Prediction of the counter outputs expected after the most recent edge.
  logic [3:0] pred_q;
  logic       pred_rco;
  logic       pred_load;

  // Next prediction computed from the stimulus seen at the current edge.
  logic [3:0] qp;
  logic [3:0] nxt_q;
  logic       nxt_rco;
  logic       nxt_load;
  logic [2:0] diff;

  assign state = cur_state;

  // The model normally runs on its own previous prediction; only the SYNC
  // cycle takes the counter's real Q so the model can lock on to it.
  always_comb begin
    qp = pred_q;
    if (cur_state == SYNC) begin
      qp = mon_Q;
    end
  end

  // Reference behaviour of the counter for one clock, given the stimulus
  // presented to it at this edge and the previous Q.
  always_comb begin
    nxt_q    = 4'd0;
    nxt_rco  = 1'b0;
    nxt_load = 1'b0;
    if (!mon_reset && mon_enable) begin
      case (mon_mode)
        2'b00: begin
          nxt_q   = qp + 4'd3;
          nxt_rco = (qp >= 4'd13);
        end
        2'b01: begin
          nxt_q   = qp - 4'd1;
          nxt_rco = (qp == 4'd0);
        end
        2'b10: begin
          nxt_q   = qp + 4'd1;
          nxt_rco = (qp == 4'd15);
        end
        default: begin
          nxt_q    = mon_D;
          nxt_load = 1'b1;
        end
      endcase
    end
  end

  // Field-by-field difference between the pending prediction and what the
  // counter actually shows now, ordered {Q, rco, load}.
  always_comb begin
    diff = {(mon_Q != pred_q), (mon_rco != pred_rco), (mon_load != pred_load)};
  end

  // Checker sequencing. Every decision uses the pre-edge state, so a compare
  // on the edge where check_en drops is simply never performed. err_pulse
  // and err_vec default to zero so they only ever last one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state   <= IDLE;
      pred_q      <= 4'd0;
      pred_rco    <= 1'b0;
      pred_load   <= 1'b0;
      err_pulse   <= 1'b0;
      err_vec     <= 3'b000;
      err_count   <= 8'd0;
      match_count <= 8'd0;
    end else begin
      err_pulse <= 1'b0;
      err_vec   <= 3'b000;
      case (cur_state)
        IDLE: begin
          if (check_en) begin
            cur_state <= SYNC;
          end
        end
        SYNC: begin
          if (!check_en) begin
            cur_state <= IDLE;
          end else begin
            pred_q    <= nxt_q;
            pred_rco  <= nxt_rco;
            pred_load <= nxt_load;
            cur_state <= CHECK;
          end
        end
        CHECK: begin
          if (!check_en) begin
            cur_state <= IDLE;
          end else begin
            pred_q    <= nxt_q;
            pred_rco  <= nxt_rco;
            pred_load <= nxt_load;
            if (|diff) begin
              err_pulse <= 1'b1;
              err_vec   <= diff;
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
              // The compare that brings the count to 255 stops checking.
              if (err_count >= 8'hFE) begin
                cur_state <= HALT;
              end
            end else begin
              match_count <= match_count + 8'd1;
            end
          end
        end
        HALT: begin
          cur_state <= HALT;
        end
        default: begin
          cur_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_4b_checker.sv
// tb_counter_4b_checker
//
// Purpose:
//   Directed bench for counter_4b_checker. The bench plays the role of the
//   monitored counter, driving mon_* values cycle by cycle, and compares the
//   checker outputs against hand-computed expectations.
//
// Ports: none (top-level bench).

module tb_counter_4b_checker;

  logic       clk;
  logic       reset;
  logic       check_en;
  logic       mon_reset;
  logic       mon_enable;
  logic [1:0] mon_mode;
  logic [3:0] mon_D;
  logic [3:0] mon_Q;
  logic       mon_rco;
  logic       mon_load;
  logic       err_pulse;
  logic [2:0] err_vec;
  logic [7:0] err_count;
  logic [7:0] match_count;
  logic [1:0] state;

  int checkCount;
  int errorCount;

  counter_4b_checker dut (
    .clk         (clk),
    .reset       (reset),
    .check_en    (check_en),
    .mon_reset   (mon_reset),
    .mon_enable  (mon_enable),
    .mon_mode    (mon_mode),
    .mon_D       (mon_D),
    .mon_Q       (mon_Q),
    .mon_rco     (mon_rco),
    .mon_load    (mon_load),
    .err_pulse   (err_pulse),
    .err_vec     (err_vec),
    .err_count   (err_count),
    .match_count (match_count),
    .state       (state)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, let one rising edge pass, and return at the
  // following falling edge where registered outputs are stable.
  task automatic applyStimulus(input logic rstn, input logic chk,
                               input logic mrst, input logic men,
                               input logic [1:0] mode, input logic [3:0] d,
                               input logic [3:0] q, input logic rco,
                               input logic load);
    reset      = rstn;
    check_en   = chk;
    mon_reset  = mrst;
    mon_enable = men;
    mon_mode   = mode;
    mon_D      = d;
    mon_Q      = q;
    mon_rco    = rco;
    mon_load   = load;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reset the checker, pass through IDLE and SYNC, and leave it in CHECK
  // with a prediction seeded from 'seed' and the given mode/data.
  task automatic startRun(input logic [3:0] seed, input logic [1:0] mode,
                          input logic [3:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, mode, d, seed, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, mode, d, seed, 1'b0, 1'b0);
    checkOutput("start_sync_state", state, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, mode, d, seed, 1'b0, 1'b0);
    checkOutput("start_check_state", state, 2);
  endtask

  initial begin
    logic [3:0] q;
    logic       rco;

    checkCount = 0;
    errorCount = 0;

    // Reset state, with every other input trying to provoke activity.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd5, 1'b1, 1'b1);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_err_pulse", err_pulse, 0);
    checkOutput("rst_err_vec", err_vec, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_match_count", match_count, 0);

    // Mode 10 counting correctly from 0: SYNC sees 0, then 19 compares
    // covering the 15 -> 0 wrap where rco must be 1.
    startRun(4'd0, 2'b10, 4'd0);
    for (int k = 1; k <= 19; k++) begin
      q   = k[3:0];
      rco = (k == 16);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, q, rco, 1'b0);
      checkOutput("up_no_pulse", err_pulse, 0);
    end
    checkOutput("up_state", state, 2);
    checkOutput("up_err_count", err_count, 0);
    checkOutput("up_match_count", match_count, 19);

    // Mode 00 from 12: 15 (rco 0), then 2 (rco 1) are both correct.
    startRun(4'd12, 2'b00, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 4'd0, 4'd15, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 4'd0, 4'd2, 1'b1, 1'b0);
    checkOutput("p3_ok_pulse", err_pulse, 0);
    checkOutput("p3_ok_match", match_count, 2);
    checkOutput("p3_ok_errs", err_count, 0);

    // Same run but rco missing on the wrap step.
    startRun(4'd12, 2'b00, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 4'd0, 4'd15, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 4'd0, 4'd2, 1'b0, 1'b0);
    checkOutput("p3_bad_pulse", err_pulse, 1);
    checkOutput("p3_bad_vec", err_vec, 3'b010);
    checkOutput("p3_bad_errs", err_count, 1);
    // Model keeps running from its own Q=2: next is 5, rco 0.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 4'd0, 4'd5, 1'b0, 1'b0);
    checkOutput("p3_pulse_drop", err_pulse, 0);
    checkOutput("p3_pulse_vec0", err_vec, 0);
    checkOutput("p3_after_match", match_count, 2);

    // Mode 11 load of 9: wrong Q, then correct Q but load missing.
    startRun(4'd4, 2'b11, 4'd9);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 4'd9, 4'd8, 1'b0, 1'b1);
    checkOutput("ld_q_pulse", err_pulse, 1);
    checkOutput("ld_q_vec", err_vec, 3'b100);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 4'd9, 4'd9, 1'b0, 1'b0);
    checkOutput("ld_load_vec", err_vec, 3'b001);
    checkOutput("ld_errs", err_count, 2);

    // Mode 01 from 0 wraps to 15 with rco; enable low gives all zero;
    // then down from 0 again; then counter reset gives all zero.
    startRun(4'd0, 2'b01, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 4'd0, 4'd15, 1'b1, 1'b0);
    checkOutput("dn_wrap_pulse", err_pulse, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("dn_dis_pulse", err_pulse, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 4'd0, 4'd15, 1'b1, 1'b0);
    checkOutput("dn_rewrap_pulse", err_pulse, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("dn_mrst_pulse", err_pulse, 0);
    checkOutput("dn_match", match_count, 4);
    checkOutput("dn_errs", err_count, 0);

    // Mismatch on every compare (load stuck high in mode 10) until HALT.
    startRun(4'd0, 2'b10, 4'd0);
    for (int i = 1; i <= 260; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd0, 1'b0, 1'b1);
      if (i == 254) begin
        checkOutput("sat_254_state", state, 2);
        checkOutput("sat_254_count", err_count, 254);
      end
      if (i == 255) begin
        checkOutput("sat_255_state", state, 3);
        checkOutput("sat_255_count", err_count, 255);
        checkOutput("sat_255_pulse", err_pulse, 1);
      end
    end
    checkOutput("halt_state", state, 3);
    checkOutput("halt_count", err_count, 255);
    checkOutput("halt_pulse", err_pulse, 0);
    checkOutput("halt_match", match_count, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd0, 1'b0, 1'b1);
    checkOutput("halt_rst_state", state, 0);
    checkOutput("halt_rst_count", err_count, 0);
    checkOutput("halt_rst_pulse", err_pulse, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("halt_rel_state", state, 1);

    // check_en toggled mid-run: the compare on the falling edge is dropped,
    // one IDLE cycle, one SYNC cycle, then CHECK resumes with counts kept.
    startRun(4'd0, 2'b10, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd3, 1'b0, 1'b0);
    checkOutput("tog_pre_match", match_count, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 4'd12, 1'b1, 1'b1);
    checkOutput("tog_idle_state", state, 0);
    checkOutput("tog_idle_pulse", err_pulse, 0);
    checkOutput("tog_idle_errs", err_count, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd12, 1'b1, 1'b1);
    checkOutput("tog_sync_state", state, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd7, 1'b1, 1'b1);
    checkOutput("tog_seed_state", state, 2);
    checkOutput("tog_seed_pulse", err_pulse, 0);
    checkOutput("tog_seed_match", match_count, 3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd8, 1'b0, 1'b0);
    checkOutput("tog_resume_match", match_count, 4);
    checkOutput("tog_resume_errs", err_count, 0);

    // Reset mid-CHECK drops the pending compare and needs SYNC again.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd0, 1'b1, 1'b1);
    checkOutput("midrst_pulse", err_pulse, 0);
    checkOutput("midrst_match", match_count, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 4'd0, 1'b1, 1'b1);
    checkOutput("midrst_sync", state, 1);
    checkOutput("midrst_no_cmp", err_count, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
